// File: rtl/sumcheck_round_verify.sv
// sumcheck_round_verify: checks each degree-2 round message against the running claim
// and folds it to p(tau) through one shared modular adder and one modular multiplier.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module field_adder (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic [`F_NBITS-1:0] a,
  input  logic [`F_NBITS-1:0] b,
  output logic [`F_NBITS-1:0] out,
  output logic                ready
);
  logic [`F_NBITS:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign ready = ~en;
  always_ff @(posedge clk)
    if (!rstb) out <= '0;
    else if (en) out <= (sum >= {1'b0, `F_Q}) ? `F_NBITS'(sum - {1'b0, `F_Q}) : sum[`F_NBITS-1:0];
endmodule

module field_multiplier (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic [`F_NBITS-1:0] a,
  input  logic [`F_NBITS-1:0] b,
  output logic [`F_NBITS-1:0] out,
  output logic                ready
);
  logic [2*`F_NBITS-1:0] prod;
  logic [`F_NBITS:0]     fold;
  // Folding high into low reduces mod 2^n-1; one conditional subtract finishes it.
  assign prod = {{`F_NBITS{1'b0}}, a} * {{`F_NBITS{1'b0}}, b};
  assign fold = {1'b0, prod[`F_NBITS-1:0]} + {1'b0, prod[2*`F_NBITS-1:`F_NBITS]};
  assign ready = ~en;
  always_ff @(posedge clk)
    if (!rstb) out <= '0;
    else if (en) out <= (fold >= {1'b0, `F_Q}) ? `F_NBITS'(fold - {1'b0, `F_Q}) : fold[`F_NBITS-1:0];
endmodule

module sumcheck_round_verify #(
  parameter int nrounds = 8,
  localparam int nrbits = $clog2(nrounds + 1)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic                restart,
  input  logic [`F_NBITS-1:0] claim_init,
  input  logic [`F_NBITS-1:0] tau,
  input  logic [`F_NBITS-1:0] p_in [2:0],
  output logic                ready,
  output logic [`F_NBITS-1:0] claim_out,
  output logic                fail,
  output logic                done,
  output logic [nrbits-1:0]   round_cnt
);
  localparam int n = `F_NBITS;
  localparam logic [n-1:0] q = `F_Q;
  localparam logic [n:0] q1 = {1'b0, q} + 1'b1;
  localparam logic [n-1:0] INV2 = q1[n:1];
  localparam logic [n-1:0] one = n'(1);
  typedef enum logic [3:0] {ST_IDLE, ST_SUM, ST_D1, ST_E, ST_D2, ST_H, ST_G, ST_K, ST_M, ST_OUT} state_t;
  state_t state, state_n;
  logic en_dly, start, go, adv, use_add, use_mul, neg;
  logic add_en, mul_en, add_rdy, mul_rdy;
  logic [n-1:0] add_a, add_bs, add_b, mul_a, mul_b, add_out, mul_out;
  logic [n-1:0] s, d1, x, h, t1, g, m, claim_reg;

  function automatic logic adds(input state_t st);
    return st inside {ST_SUM, ST_D1, ST_E, ST_D2, ST_H, ST_K, ST_OUT};
  endfunction
  function automatic logic muls(input state_t st);
    return st inside {ST_H, ST_G, ST_M};
  endfunction

  assign start = en & ~en_dly;
  assign go = start & (state == ST_IDLE) & (restart | ~done);
  assign ready = (state == ST_IDLE) & ~go;
  assign claim_out = claim_reg;
  assign add_b = (neg && add_bs != '0) ? q - add_bs : add_bs;

  field_adder u_add (.clk(clk), .rstb(rstb), .en(add_en), .a(add_a), .b(add_b), .out(add_out), .ready(add_rdy));
  field_multiplier u_mul (.clk(clk), .rstb(rstb), .en(mul_en), .a(mul_a), .b(mul_b), .out(mul_out), .ready(mul_rdy));

  // x is reused for e, then d2, then k.
  always_comb begin
    add_a = '0;
    add_bs = '0;
    neg = 1'b0;
    mul_a = '0;
    mul_b = '0;
    case (state)
      ST_SUM: begin add_a = p_in[0]; add_bs = p_in[1]; end
      ST_D1:  begin add_a = p_in[1]; add_bs = p_in[0]; neg = 1'b1; end
      ST_E:   begin add_a = p_in[2]; add_bs = p_in[1]; neg = 1'b1; end
      ST_D2:  begin add_a = x; add_bs = d1; neg = 1'b1; end
      ST_H:   begin add_a = tau; add_bs = one; neg = 1'b1; mul_a = x; mul_b = INV2; end
      ST_G:   begin mul_a = t1; mul_b = h; end
      ST_K:   begin add_a = d1; add_bs = g; end
      ST_M:   begin mul_a = tau; mul_b = x; end
      ST_OUT: begin add_a = p_in[0]; add_bs = m; end
      default: ;
    endcase
    use_add = adds(state);
    use_mul = muls(state);
    adv = (state != ST_IDLE) & (~use_add | add_rdy) & (~use_mul | mul_rdy);
    state_n = go ? ST_SUM : adv ? (state == ST_OUT ? ST_IDLE : state_t'(state + 1'b1)) : state;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= ST_IDLE;
      en_dly <= 1'b1;
      add_en <= 1'b0;
      mul_en <= 1'b0;
      claim_reg <= '0;
      fail <= 1'b0;
      done <= 1'b0;
      round_cnt <= '0;
    end else begin
      state <= state_n;
      en_dly <= en;
      add_en <= (state_n != state) & adds(state_n);
      mul_en <= (state_n != state) & muls(state_n);
      if (go && restart) begin
        claim_reg <= claim_init;
        fail <= 1'b0;
        done <= 1'b0;
        round_cnt <= '0;
      end
      if (adv && state == ST_D1 && s != claim_reg) fail <= 1'b1;
      if (adv && state == ST_OUT) begin
        claim_reg <= add_out;
        if (round_cnt != nrbits'(nrounds)) round_cnt <= round_cnt + 1'b1;
        if (round_cnt + 1'b1 == nrbits'(nrounds)) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk)
    if (adv)
      case (state)
        ST_SUM: s <= add_out;
        ST_D1: d1 <= add_out;
        ST_E, ST_D2, ST_K: x <= add_out;
        ST_H: begin h <= mul_out; t1 <= add_out; end
        ST_G: g <= mul_out;
        ST_M: m <= mul_out;
        default: ;
      endcase
endmodule

// File: tb/tb_sumcheck_round_verify.sv
// tb_sumcheck_round_verify: directed and random rounds against a Lagrange-form model of p(tau).
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_sumcheck_round_verify;
  typedef logic [`F_NBITS-1:0] fe_t;
  localparam int NR = 2;
  localparam int RB = $clog2(NR + 1);
  localparam fe_t Q = `F_Q;
  localparam fe_t INV2 = fe_t'((128'(Q) + 128'd1) / 128'd2);

  logic clk = 0, rstb = 0, en = 0, restart = 0;
  fe_t claim_init = '0, tau = '0;
  fe_t p_in [2:0];
  logic ready, fail, done;
  fe_t claim_out;
  logic [RB-1:0] round_cnt;

  int total = 0, bad = 0;
  bit chk_en = 0, busy = 0;
  fe_t m_claim = '0;
  bit m_fail = 0, m_done = 0;
  int m_cnt = 0;

  sumcheck_round_verify #(.nrounds(NR)) dut (
    .clk(clk), .rstb(rstb), .en(en), .restart(restart), .claim_init(claim_init),
    .tau(tau), .p_in(p_in), .ready(ready), .claim_out(claim_out), .fail(fail),
    .done(done), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  function automatic fe_t addm(input fe_t a, input fe_t b);
    return fe_t'((128'(a) + 128'(b)) % 128'(Q));
  endfunction
  function automatic fe_t subm(input fe_t a, input fe_t b);
    return addm(a, fe_t'((128'(Q) - 128'(b)) % 128'(Q)));
  endfunction
  function automatic fe_t mulm(input fe_t a, input fe_t b);
    return fe_t'((128'(a) * 128'(b)) % 128'(Q));
  endfunction
  // Lagrange basis on nodes 0,1,2.
  function automatic fe_t p_at(input fe_t a0, input fe_t a1, input fe_t a2, input fe_t t);
    fe_t l0, l1, l2;
    l0 = mulm(mulm(subm(t, 1), subm(t, 2)), INV2);
    l1 = subm(0, mulm(t, subm(t, 2)));
    l2 = mulm(mulm(t, subm(t, 1)), INV2);
    return addm(addm(mulm(a0, l0), mulm(a1, l1)), mulm(a2, l2));
  endfunction
  function automatic fe_t rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom % 8)
      0: return '0;
      1: return Q - 1;
      default: return fe_t'(r % 64'(Q));
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en && !busy) begin
      chk("ready", ready, 1);
      chk("claim_out", claim_out, m_claim);
      chk("fail", fail, m_fail);
      chk("done", done, m_done);
      chk("round_cnt", round_cnt, m_cnt);
    end
  end

  task automatic model_round(input bit rs, input fe_t ci, input fe_t a0, input fe_t a1, input fe_t a2, input fe_t t);
    if (rs) begin
      m_claim = ci;
      m_fail = 0;
      m_done = 0;
      m_cnt = 0;
    end
    if (addm(a0, a1) != m_claim) m_fail = 1;
    m_claim = p_at(a0, a1, a2, t);
    if (m_cnt < NR) m_cnt++;
    if (m_cnt == NR) m_done = 1;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_timeout actual=0 required=1 t=%0t", $time);
    end
  endtask

  task automatic do_round(input bit rs, input fe_t ci, input fe_t a0, input fe_t a1, input fe_t a2, input fe_t t, input bit poke);
    bit acc;
    @(negedge clk);
    restart = rs;
    claim_init = ci;
    p_in[0] = a0;
    p_in[1] = a1;
    p_in[2] = a2;
    tau = t;
    acc = rs || !m_done;
    if (acc) begin
      busy = 1;
      model_round(rs, ci, a0, a1, a2, t);
    end
    en = 1;
    if (acc) begin
      if (poke) begin
        @(negedge clk);
        en = 0;
        repeat (12) @(negedge clk);
        chk("busy_mid", ready, 0);
        en = 1;
      end
      wait_ready();
      busy = 0;
      if (poke) repeat (4) @(negedge clk);
    end else @(negedge clk);
    en = 0;
    @(negedge clk);
  endtask

  initial begin
    fe_t a0, a1, a2, t, ci;
    bit rs;
    p_in[0] = '0; p_in[1] = '0; p_in[2] = '0;
    en = 1;
    repeat (3) @(negedge clk);
    rstb = 1;
    chk_en = 1;
    repeat (4) @(negedge clk);
    en = 0;
    @(negedge clk);

    do_round(1, 9, 3, 6, 11, 5, 0);
    chk("t1_model", m_claim, 38);
    chk("t1_claim", claim_out, 38);
    chk("t1_fail", fail, 0);
    chk("t1_cnt", round_cnt, 1);
    do_round(0, 0, 18, 20, 22, 0, 0);
    chk("t3_claim", claim_out, 18);
    chk("t3_done", done, 1);
    chk("t3_cnt", round_cnt, 2);
    do_round(0, 0, 1, 2, 3, 4, 0);
    chk("t3_ignored", claim_out, 18);
    do_round(1, 10, 3, 6, 11, 5, 0);
    chk("t2_fail", fail, 1);
    chk("t2_claim", claim_out, 38);
    do_round(1, 9, 3, 6, 11, 5, 0);
    chk("t2_clear", fail, 0);
    do_round(1, 9, 3, 6, 11, Q - 1, 0);
    chk("t4_model", m_claim, 2);
    chk("t4_claim", claim_out, 2);
    do_round(0, 0, 5, Q - 3, Q - 1, Q - 1, 1);
    chk("t6_cnt", round_cnt, 2);

    @(negedge clk);
    restart = 1; claim_init = 9; p_in[0] = 3; p_in[1] = 6; p_in[2] = 11; tau = 5;
    busy = 1;
    en = 1;
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", ready, 0);
    rstb = 0;
    en = 0;
    @(negedge clk);
    rstb = 1;
    m_claim = '0; m_fail = 0; m_done = 0; m_cnt = 0;
    busy = 0;
    repeat (2) @(negedge clk);
    do_round(1, 9, 3, 6, 11, 5, 0);
    chk("t5_claim", claim_out, 38);

    for (int i = 0; i < 40; i++) begin
      rs = ($urandom % 4 == 0) || i == 0;
      a0 = rnd(); a2 = rnd(); t = rnd();
      if (rs) begin
        a1 = rnd();
        ci = ($urandom % 4 != 0) ? addm(a0, a1) : rnd();
      end else begin
        ci = rnd();
        a1 = ($urandom % 4 != 0) ? subm(m_claim, a0) : rnd();
      end
      do_round(rs, ci, a0, a1, a2, t, 0);
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
